mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between instruction fetch and the memory-stage load/store unit.
- Accepts one request at a time and latches it. Drives the memory port with a req/gnt handshake, then routes the read response (or write ack) back to the requester that owns the transaction.
- Fixed priority to data accesses, with a starvation limit that forces a fetch grant.
- Read data is passed through raw. Sign/zero extension happens in the memory-stage unit.

Parameters:
- STARVE_MAX, 4: number of consecutive data-over-fetch wins after which a pending fetch must win. Legal range 1..15.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- instr_req_i  in  1  fetch request; held with its address until instr_gnt_o
- instr_addr_i  in  64  fetch address; read-only, size always 2'b11
- instr_gnt_o  out  1  fetch request accepted by memory
- instr_rvalid_o  out  1  fetch data valid
- instr_rdata_o  out  64  fetch data
- data_req_i  in  1  load/store request; held with its fields until data_gnt_o
- data_addr_i  in  64  load/store address
- data_byte_en_i  in  2  access size: 00 byte, 01 half, 10 word, 11 double
- data_wr_i  in  1  1 = store
- data_wr_data_i  in  64  store data
- data_gnt_o  out  1  load/store accepted by memory
- data_rvalid_o  out  1  load data valid, or store acknowledge
- data_rdata_o  out  64  load data
- mem_req_o  out  1  memory request
- mem_addr_o  out  64  memory address
- mem_byte_en_o  out  2  memory access size
- mem_wr_o  out  1  memory write
- mem_wr_data_o  out  64  memory write data
- mem_gnt_i  in  1  memory accepts request
- mem_rvalid_i  in  1  memory response valid; also returned for writes
- mem_rdata_i  in  64  memory read data
- err_o  out  1  sticky: mem_rvalid_i seen outside RSP

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - state=IDLE, owner=DATA, starve_cnt=0, err_o=0.
  - All mem_* outputs 0.
  - All gnt/rvalid outputs 0; rdata outputs 0.
  - Reset mid-transaction abandons it; no response is forwarded afterwards.
- States: IDLE, REQ, RSP (2-bit encoded).
- IDLE:
  - If any request is asserted, select a winner and register into the mem_* output registers: the winner's address, size and store data; wr=0 for fetch; size 11 for fetch; mem_req_o=1. Go to REQ.
  - Latency: request seen at edge N, mem_req_o high after edge N. Nothing is forwarded combinationally to the memory.
- Winner selection:
  - Only data_req_i: DATA.
  - Only instr_req_i: INSTR.
  - Both asserted and starve_cnt<STARVE_MAX: DATA; starve_cnt++.
  - Both asserted and starve_cnt==STARVE_MAX: INSTR.
  - starve_cnt clears to 0 whenever INSTR wins; otherwise it holds.
- REQ:
  - mem_req_o and all mem_* fields held stable.
  - On mem_gnt_i=1: owner's gnt_o=1 in the same cycle (combinational: state==REQ & mem_gnt_i & owner match); mem_req_o=0 from the next cycle; go to RSP.
  - The non-owner's gnt_o is never asserted.
- RSP:
  - On mem_rvalid_i=1: owner's rvalid_o=1 and rdata_o=mem_rdata_i in the same cycle (combinational pass-through); go to IDLE.
  - Non-owner rvalid_o=0; its rdata_o=0.
  - Requests arriving in REQ or RSP are not sampled; they wait for IDLE.
- Throughput: at most one outstanding transaction. Minimum 3 cycles per transaction (IDLE→REQ→RSP with gnt and rvalid each arriving in the first cycle of their state).
- mem_gnt_i outside REQ: ignored.
- mem_rvalid_i outside RSP: ignored for routing; sets err_o=1, which clears only on reset.
- Simultaneous mem_gnt_i and mem_rvalid_i in REQ: gnt is taken; rvalid sets err_o.
- A requester dropping req before its gnt is a protocol violation: the latched transaction still completes and its response still routes to that requester.

Test Plan:
- Single fetch: instr_req_i=1, addr 0x1000; mem_gnt_i one cycle after mem_req_o; mem_rvalid_i 2 cycles later with rdata 0xDEADBEEF_00000013 → mem_req_o rises 1 cycle after the request; mem_addr_o=0x1000, mem_byte_en_o=11, mem_wr_o=0; instr_gnt_o pulses with mem_gnt_i; instr_rvalid_o/instr_rdata_o match the response; data_* gnt/rvalid stay 0.
- Store: data_req_i=1, wr=1, addr 0x2004, size 10, wdata 0xCAFE → mem_wr_o=1 and fields match; data_rvalid_o pulses on mem_rvalid_i; err_o=0.
- Contention and starvation: both requests held continuously, STARVE_MAX=4 → grant order DATA,DATA,DATA,DATA,INSTR,DATA…; starve_cnt returns to 0 after the INSTR win.
- Backpressure: mem_gnt_i held low 10 cycles → mem_req_o and all mem_* fields stay constant for those 10 cycles, no gnt_o, and a newly arriving request is not sampled.
- Spurious response: mem_rvalid_i pulsed in IDLE → no rvalid_o asserted; err_o=1 and stays 1 until reset_n=0.
- Reset mid-op: assert reset_n=0 in RSP, release, then pulse mem_rvalid_i → all outputs 0 and state IDLE immediately on assertion; the late response is not routed and sets err_o.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store.
// Data has priority; a starvation counter forces a fetch win after STARVE_MAX data wins.
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        instr_req_i,
    input  logic [63:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [63:0] instr_rdata_o,
    input  logic        data_req_i,
    input  logic [63:0] data_addr_i,
    input  logic [1:0]  data_byte_en_i,
    input  logic        data_wr_i,
    input  logic [63:0] data_wr_data_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [63:0] data_rdata_o,
    output logic        mem_req_o,
    output logic [63:0] mem_addr_o,
    output logic [1:0]  mem_byte_en_o,
    output logic        mem_wr_o,
    output logic [63:0] mem_wr_data_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [63:0] mem_rdata_i,
    output logic        err_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RSP = 2'd2} state_t;
    typedef enum logic {OWN_DATA = 1'b0, OWN_INSTR = 1'b1} owner_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state, state_nxt;
    owner_t      owner, owner_nxt;
    logic [3:0]  starve_cnt, starve_nxt;
    logic        mem_req_nxt, mem_wr_nxt, err_nxt;
    logic [63:0] mem_addr_nxt, mem_wr_data_nxt;
    logic [1:0]  mem_byte_en_nxt;
    logic        rsp_fire;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            owner         <= OWN_DATA;
            starve_cnt    <= '0;
            err_o         <= 1'b0;
            mem_req_o     <= 1'b0;
            mem_addr_o    <= '0;
            mem_byte_en_o <= '0;
            mem_wr_o      <= 1'b0;
            mem_wr_data_o <= '0;
        end else begin
            state         <= state_nxt;
            owner         <= owner_nxt;
            starve_cnt    <= starve_nxt;
            err_o         <= err_nxt;
            mem_req_o     <= mem_req_nxt;
            mem_addr_o    <= mem_addr_nxt;
            mem_byte_en_o <= mem_byte_en_nxt;
            mem_wr_o      <= mem_wr_nxt;
            mem_wr_data_o <= mem_wr_data_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        owner_nxt       = owner;
        starve_nxt      = starve_cnt;
        mem_req_nxt     = mem_req_o;
        mem_addr_nxt    = mem_addr_o;
        mem_byte_en_nxt = mem_byte_en_o;
        mem_wr_nxt      = mem_wr_o;
        mem_wr_data_nxt = mem_wr_data_o;
        err_nxt         = err_o | (mem_rvalid_i & (state != RSP));
        case (state)
            IDLE: begin
                if (instr_req_i || data_req_i) begin
                    // Fetch wins when alone, or when data has already won STARVE_MAX times in a row
                    if (instr_req_i && (!data_req_i || starve_cnt >= STARVE_LIM)) begin
                        owner_nxt       = OWN_INSTR;
                        starve_nxt      = '0;
                        mem_addr_nxt    = instr_addr_i;
                        mem_byte_en_nxt = 2'b11;
                        mem_wr_nxt      = 1'b0;
                        mem_wr_data_nxt = '0;
                    end else begin
                        owner_nxt       = OWN_DATA;
                        if (instr_req_i) starve_nxt = starve_cnt + 4'd1;
                        mem_addr_nxt    = data_addr_i;
                        mem_byte_en_nxt = data_byte_en_i;
                        mem_wr_nxt      = data_wr_i;
                        mem_wr_data_nxt = data_wr_data_i;
                    end
                    mem_req_nxt = 1'b1;
                    state_nxt   = REQ;
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    mem_req_nxt = 1'b0;
                    state_nxt   = RSP;
                end
            end
            RSP: begin
                if (mem_rvalid_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rsp_fire       = (state == RSP) & mem_rvalid_i;
    assign instr_gnt_o    = (state == REQ) & mem_gnt_i & (owner == OWN_INSTR);
    assign data_gnt_o     = (state == REQ) & mem_gnt_i & (owner == OWN_DATA);
    assign instr_rvalid_o = rsp_fire & (owner == OWN_INSTR);
    assign data_rvalid_o  = rsp_fire & (owner == OWN_DATA);
    assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
    assign data_rdata_o   = data_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level model checked every cycle,
// plus literal expectations for each scenario.
module tb_mem_port_arbiter;

    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        instr_req_i = 1'b0;
    logic [63:0] instr_addr_i = '0;
    logic        instr_gnt_o, instr_rvalid_o;
    logic [63:0] instr_rdata_o;
    logic        data_req_i = 1'b0;
    logic [63:0] data_addr_i = '0;
    logic [1:0]  data_byte_en_i = '0;
    logic        data_wr_i = 1'b0;
    logic [63:0] data_wr_data_i = '0;
    logic        data_gnt_o, data_rvalid_o;
    logic [63:0] data_rdata_o;
    logic        mem_req_o;
    logic [63:0] mem_addr_o;
    logic [1:0]  mem_byte_en_o;
    logic        mem_wr_o;
    logic [63:0] mem_wr_data_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [63:0] mem_rdata_i = '0;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.STARVE_MAX(SM)) dut (
        .clk(clk), .reset_n(reset_n),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_byte_en_i(data_byte_en_i),
        .data_wr_i(data_wr_i), .data_wr_data_i(data_wr_data_i),
        .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_byte_en_o(mem_byte_en_o),
        .mem_wr_o(mem_wr_o), .mem_wr_data_o(mem_wr_data_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: one pending transaction, granted or not.
    bit          m_busy, m_granted, m_instr, m_wr, m_err, pick_instr;
    logic [63:0] m_addr, m_wdata;
    logic [1:0]  m_be;
    int          m_wins;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 0; m_granted = 0; m_instr = 0; m_wr = 0; m_err = 0;
            m_addr = '0; m_wdata = '0; m_be = '0; m_wins = 0;
        end else begin
            if (mem_rvalid_i && !(m_busy && m_granted)) m_err = 1;
            if (!m_busy) begin
                if (instr_req_i || data_req_i) begin
                    if (instr_req_i && data_req_i) pick_instr = (m_wins >= SM);
                    else pick_instr = instr_req_i;
                    if (pick_instr) begin
                        m_wins = 0;
                        m_addr = instr_addr_i; m_be = 2'b11; m_wr = 0; m_wdata = '0;
                    end else begin
                        if (instr_req_i) m_wins++;
                        m_addr = data_addr_i; m_be = data_byte_en_i;
                        m_wr = data_wr_i; m_wdata = data_wr_data_i;
                    end
                    m_instr = pick_instr; m_busy = 1; m_granted = 0;
                end
            end else if (!m_granted) begin
                if (mem_gnt_i) m_granted = 1;
            end else if (mem_rvalid_i) begin
                m_busy = 0;
            end
        end
    end

    bit dut_order[$];
    bit log_en = 0;

    always @(negedge clk) begin
        logic waiting, answering;
        waiting   = m_busy && !m_granted;
        answering = m_busy && m_granted && mem_rvalid_i;
        chk("mem_req", mem_req_o, waiting);
        chk("mem_addr", mem_addr_o, m_addr);
        chk("mem_be", mem_byte_en_o, m_be);
        chk("mem_wr", mem_wr_o, m_wr);
        chk("mem_wdata", mem_wr_data_o, m_wdata);
        chk("instr_gnt", instr_gnt_o, waiting && m_instr && mem_gnt_i);
        chk("data_gnt", data_gnt_o, waiting && !m_instr && mem_gnt_i);
        chk("instr_rvalid", instr_rvalid_o, answering && m_instr);
        chk("data_rvalid", data_rvalid_o, answering && !m_instr);
        chk("instr_rdata", instr_rdata_o, (answering && m_instr) ? mem_rdata_i : 64'd0);
        chk("data_rdata", data_rdata_o, (answering && !m_instr) ? mem_rdata_i : 64'd0);
        chk("err", err_o, m_err);
        if (log_en && instr_gnt_o) dut_order.push_back(1'b1);
        if (log_en && data_gnt_o) dut_order.push_back(1'b0);
    end

    initial begin
        // Reset state
        step();
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_err", err_o, 0);
        reset_n = 1'b1;
        step();

        // Single fetch
        instr_req_i = 1'b1; instr_addr_i = 64'h1000;
        step();
        chk("f_mem_req", mem_req_o, 1);
        chk("f_mem_addr", mem_addr_o, 64'h1000);
        chk("f_mem_be", mem_byte_en_o, 2'b11);
        chk("f_mem_wr", mem_wr_o, 0);
        step();
        mem_gnt_i = 1'b1; #1;
        chk("f_instr_gnt", instr_gnt_o, 1);
        chk("f_data_gnt", data_gnt_o, 0);
        step();
        mem_gnt_i = 1'b0; instr_req_i = 1'b0;
        chk("f_mem_req_drop", mem_req_o, 0);
        step();
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'hDEADBEEF_00000013; #1;
        chk("f_instr_rvalid", instr_rvalid_o, 1);
        chk("f_instr_rdata", instr_rdata_o, 64'hDEADBEEF_00000013);
        chk("f_data_rvalid", data_rvalid_o, 0);
        step();
        mem_rvalid_i = 1'b0;

        // Store
        data_req_i = 1'b1; data_wr_i = 1'b1; data_addr_i = 64'h2004;
        data_byte_en_i = 2'b10; data_wr_data_i = 64'hCAFE;
        step();
        chk("s_mem_wr", mem_wr_o, 1);
        chk("s_mem_addr", mem_addr_o, 64'h2004);
        chk("s_mem_be", mem_byte_en_o, 2'b10);
        chk("s_mem_wdata", mem_wr_data_o, 64'hCAFE);
        mem_gnt_i = 1'b1; #1;
        chk("s_data_gnt", data_gnt_o, 1);
        step();
        mem_gnt_i = 1'b0; data_req_i = 1'b0; data_wr_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'h0; #1;
        chk("s_data_rvalid", data_rvalid_o, 1);
        step();
        mem_rvalid_i = 1'b0;
        chk("s_err", err_o, 0);

        // Contention: both held for 10 transactions
        instr_req_i = 1'b1; instr_addr_i = 64'h5000;
        data_req_i = 1'b1; data_addr_i = 64'h6000; data_byte_en_i = 2'b11;
        dut_order.delete();
        log_en = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            mem_gnt_i = 1'b1;
            step();
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 64'(i + 100);
            step();
            mem_rvalid_i = 1'b0;
        end
        instr_req_i = 1'b0; data_req_i = 1'b0;
        log_en = 0;
        chk("c_count", dut_order.size(), 10);
        for (int i = 0; i < 10 && i < dut_order.size(); i++)
            chk($sformatf("c_order%0d", i), dut_order[i], (i == 4 || i == 9) ? 1 : 0);

        // Backpressure: gnt low for 10 cycles, late fetch must not be sampled
        data_req_i = 1'b1; data_addr_i = 64'h3000; data_byte_en_i = 2'b01;
        step();
        instr_req_i = 1'b1; instr_addr_i = 64'h4000;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("b_mem_req", mem_req_o, 1);
            chk("b_mem_addr", mem_addr_o, 64'h3000);
            chk("b_mem_be", mem_byte_en_o, 2'b01);
            chk("b_gnts", {instr_gnt_o, data_gnt_o}, 2'b00);
        end
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0; data_req_i = 1'b0; instr_req_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'h77; #1;
        chk("b_data_rdata", data_rdata_o, 64'h77);
        step();
        mem_rvalid_i = 1'b0;

        // Spurious response in IDLE
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'h55; #1;
        chk("sp_rvalids", {instr_rvalid_o, data_rvalid_o}, 2'b00);
        step();
        mem_rvalid_i = 1'b0;
        chk("sp_err", err_o, 1);
        step(); step();
        chk("sp_err_sticky", err_o, 1);

        // Reset mid-transaction
        data_req_i = 1'b1; data_addr_i = 64'h8000;
        step();
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0; data_req_i = 1'b0;
        reset_n = 1'b0; #1;
        chk("r_mem_req", mem_req_o, 0);
        chk("r_mem_addr", mem_addr_o, 0);
        chk("r_err", err_o, 0);
        step();
        reset_n = 1'b1;
        step();
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'h99; #1;
        chk("r_late_rvalid", data_rvalid_o, 0);
        step();
        mem_rvalid_i = 1'b0;
        chk("r_late_err", err_o, 1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
